rc4_prga_decrypt: RTL and testbench
===================================

// Module: rc4_prga_decrypt
// PURPOSE
//  RC4 keystream (PRGA) decrypt engine. Runs after KSA has filled the 256-byte S RAM.
//  Swaps S in place, XORs each keystream byte with ciphertext ROM byte k, and writes the
//  result to decrypt RAM byte k. Start/done handshake, parametrised message length and RAM read
//  latency. Sits between the KSA engine and the key-search controller.
// PARAMETERS
//  MSG_LEN     32  message bytes processed per run (1..2**MSG_AW)
//  MSG_AW      5   address width of message ROM / decrypt RAM
//  MEM_RD_LAT  1   read latency, addr->data, of S RAM and message ROM (1 or 2 cycles)
// PORTS
//  clk      in   1       clock
//  reset    in   1       asynchronous, active-high
//  start    in   1       begin run; sampled in IDLE only
//  busy     out  1       high from cycle after start accepted until done
//  done     out  1       one-cycle pulse at end of run
//  fail     out  1       valid with done; 1 = run aborted by check (macro only, else 0)
//  s_addr   out  8       S RAM address
//  s_wdata  out  8       S RAM write data
//  s_we     out  1       S RAM write enable
//  s_rdata  in   8       S RAM read data
//  m_addr   out  MSG_AW  ciphertext ROM address
//  m_rdata  in   8       ciphertext ROM data
//  d_addr   out  MSG_AW  decrypt RAM address
//  d_wdata  out  8       decrypt RAM write data
//  d_we     out  1       decrypt RAM write enable
// BEHAVIOUR
//  Reset: all outputs 0. Internal i, j and k are 0. State is IDLE. Reset mid-run aborts at once.
//   No further writes occur, and no done is issued.
//  Per byte k: i=i+1; si=S[i]; j=j+si; sj=S[j]; S[i]=sj; S[j]=si; f=si+sj;
//   d[k]=S[f]^m[k]. All arithmetic is 8-bit mod 256.
//  States:
//   IDLE -> RD_SI on start.
//   RD_SI -> WT_SI x MEM_RD_LAT -> RD_SJ -> WT_SJ x L -> WR_SI -> WR_SJ -> RD_SF
//   -> WT_SF x L -> WR_D -> (k==MSG_LEN-1 ? FIN : RD_SI).
//   FIN -> IDLE.
//  Per-byte cost is 6+3*MEM_RD_LAT cycles (9 when L=1).
//  done pulses in FIN, MSG_LEN*(6+3L)+1 cycles after start is sampled. busy is low in FIN.
//  i increments on entry to RD_SI. j is updated on the last WT_SI cycle.
//  Read data is captured on the last wait cycle of each read.
//  m_addr=k is issued in RD_SF, in parallel with s_addr=f.
//  S[f] is read after both swap writes, so f==i or f==j returns the post-swap value.
//  i==j: both writes land on the same address with equal data (legal, no special case).
//  start while busy: ignored. start held high in IDLE after FIN: starts a new run.
//   A new run continues from the current i, j and S; k restarts at 0.
//  s_we is high only in WR_SI and WR_SJ; d_we is high only in WR_D.
// CONFIGURATION
//  RC4_ASCII_CHECK_EN defined:
//   Each output byte must be 8'h61..8'h7A or 8'h20.
//   On the first violation: no d write; go to FIN with fail=1.
//  RC4_ASCII_CHECK_EN undefined: fail is tied 0 and all MSG_LEN bytes are written.
// STRUCTURE
//  rc4_pkg holds:
//   the state enum;
//   the ASCII_LO/ASCII_HI/ASCII_SPACE constants;
//   the S_AW=8 width constant.
//  Sub-module rc4_byte_checker is a combinational ASCII-range check.
//   It is instantiated only under the macro.
// TESTING
//  1. S[x]=x, m=0, MSG_LEN=4, L=1 -> d[0]=8'h02, d[1]=8'h05.
//     done occurs at cycle 37 after start.
//  2. S preloaded from model KSA with key "Key", m=BB F3 16 E8 D9 40 AF 0A D3, MSG_LEN=9
//     -> d="Plaintext", fail=0 (macro off).
//  3. Same as 2 with RC4_ASCII_CHECK_EN defined -> 'P' violates the check.
//     No d write; done and fail=1 at cycle 9.
//  4. MEM_RD_LAT=2 rerun of 2 -> same data; 12 cycles/byte; done at cycle 109.
//  5. reset asserted during WR_SJ of byte 3 -> all outputs 0 immediately.
//     No further s_we or d_we; busy=0.
//  6. start pulsed while busy -> ignored; exactly one done; S state matches the model.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt engine.
package rc4_pkg;

  localparam int S_AW = 8;

  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SI,
    ST_WT_SI,
    ST_RD_SJ,
    ST_WT_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_SF,
    ST_WT_SF,
    ST_WR_D,
    ST_FIN
  } state_t;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Handshake plus S RAM / message ROM / decrypt RAM bus of the PRGA engine.
// slave = engine side, master = controller and memories side.
interface rc4_prga_decrypt_if #(parameter int MSG_AW = 5);
  import rc4_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              fail;
  logic [S_AW-1:0]   s_addr;
  logic [7:0]        s_wdata;
  logic              s_we;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] m_addr;
  logic [7:0]        m_rdata;
  logic [MSG_AW-1:0] d_addr;
  logic [7:0]        d_wdata;
  logic              d_we;

  modport slave (
    input  start, s_rdata, m_rdata,
    output busy, done, fail, s_addr, s_wdata, s_we, m_addr, d_addr, d_wdata, d_we
  );

  modport master (
    output start, s_rdata, m_rdata,
    input  busy, done, fail, s_addr, s_wdata, s_we, m_addr, d_addr, d_wdata, d_we
  );
endinterface

// File: rtl/rc4_byte_checker.sv
// Combinational test: byte is lowercase ASCII letter or space.
module rc4_byte_checker
  import rc4_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_ok
);
  assign o_ok = ((i_byte >= ASCII_LO) && (i_byte <= ASCII_HI)) || (i_byte == ASCII_SPACE);
endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA decrypt engine: swaps S in place and writes S[f]^m[k] to decrypt RAM.
// Optional macro RC4_ASCII_CHECK_EN aborts the run on the first non-text output byte.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN    = 32,
  parameter int MSG_AW     = 5,
  parameter int MEM_RD_LAT = 1
)(
  input  logic              clk,
  input  logic              reset,
  rc4_prga_decrypt_if.slave bus
);

  state_t            r_state, w_next;
  logic [S_AW-1:0]   r_i, r_j;
  logic [MSG_AW-1:0] r_k;
  logic              r_wcnt;
  logic [7:0]        r_si, r_sj, r_d;
  logic [S_AW-1:0]   w_f;
  logic [7:0]        w_byte;
  logic              w_last;
  logic              w_ok;

  assign w_f    = r_si + r_sj;
  assign w_byte = bus.s_rdata ^ bus.m_rdata;
  // Read data is valid on the final wait cycle of each access.
  assign w_last = (r_wcnt == 1'(MEM_RD_LAT - 1));

`ifdef RC4_ASCII_CHECK_EN
  logic r_fail;

  rc4_byte_checker u_chk (
    .i_byte (w_byte),
    .o_ok   (w_ok)
  );

  // Remember why the run ended so fail can accompany done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       r_fail <= 1'b0;
    else if (r_state == ST_IDLE && bus.start)        r_fail <= 1'b0;
    else if (r_state == ST_WT_SF && w_last && !w_ok) r_fail <= 1'b1;
  end
`else
  assign w_ok = 1'b1;
`endif

  // Control state: FSM, indices i/j/k and the read-wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_wcnt  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= (w_next != r_state) ? 1'b0 : r_wcnt + 1'b1;
      if (w_next == ST_RD_SI)
        r_i <= r_i + 1'b1;
      if (r_state == ST_WT_SI && w_last)
        r_j <= r_j + bus.s_rdata;
      if (r_state == ST_IDLE && bus.start)
        r_k <= '0;
      else if (r_state == ST_WR_D)
        r_k <= r_k + 1'b1;
    end
  end

  // Datapath captures of S[i], S[j] and the decrypted byte.
  always_ff @(posedge clk) begin
    if (r_state == ST_WT_SI && w_last) r_si <= bus.s_rdata;
    if (r_state == ST_WT_SJ && w_last) r_sj <= bus.s_rdata;
    if (r_state == ST_WT_SF && w_last) r_d  <= w_byte;
  end

  // Next-state and memory-port decode; S[f] is read only after both swap writes.
  always_comb begin
    w_next      = r_state;
    bus.busy    = (r_state != ST_IDLE) && (r_state != ST_FIN);
    bus.done    = 1'b0;
    bus.fail    = 1'b0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_we    = 1'b0;
    bus.m_addr  = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_we    = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_RD_SI;
      ST_RD_SI: begin
        bus.s_addr = r_i;
        w_next     = ST_WT_SI;
      end
      ST_WT_SI: if (w_last) w_next = ST_RD_SJ;
      ST_RD_SJ: begin
        bus.s_addr = r_j;
        w_next     = ST_WT_SJ;
      end
      ST_WT_SJ: if (w_last) w_next = ST_WR_SI;
      ST_WR_SI: begin
        bus.s_addr  = r_i;
        bus.s_wdata = r_sj;
        bus.s_we    = 1'b1;
        w_next      = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        bus.s_addr  = r_j;
        bus.s_wdata = r_si;
        bus.s_we    = 1'b1;
        w_next      = ST_RD_SF;
      end
      ST_RD_SF: begin
        bus.s_addr = w_f;
        bus.m_addr = r_k;
        w_next     = ST_WT_SF;
      end
      ST_WT_SF: if (w_last) w_next = w_ok ? ST_WR_D : ST_FIN;
      ST_WR_D: begin
        bus.d_addr  = r_k;
        bus.d_wdata = r_d;
        bus.d_we    = 1'b1;
        w_next      = (r_k == MSG_AW'(MSG_LEN - 1)) ? ST_FIN : ST_RD_SI;
      end
      ST_FIN: begin
        bus.done = 1'b1;
`ifdef RC4_ASCII_CHECK_EN
        bus.fail = r_fail;
`endif
        w_next   = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench: two engines (4 bytes/L=1 and 9 bytes/L=2) against a plain RC4 model.
module tb_rc4_prga_decrypt;
  import rc4_pkg::*;

`ifdef RC4_ASCII_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic       busy, done, fail, s_we, d_we;
    logic [7:0] s_addr, s_wdata;
    logic [4:0] m_addr, d_addr;
    logic [7:0] d_wdata;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst_q [2];
  logic       start_q [2];
  logic       ld [2];
  logic [7:0] mem [2][256];
  logic [7:0] init_s [2][256];
  logic [7:0] msg [2][32];
  logic [7:0] rd1 [2], rd2 [2], mr1 [2], mr2 [2];

  logic [7:0] mS [2][256];
  int         mi [2], mj [2];
  logic [7:0] expd [2][32];
  logic [7:0] dgot [2][32];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rc4_prga_decrypt_if #(.MSG_AW(5)) ifA ();
  rc4_prga_decrypt_if #(.MSG_AW(5)) ifB ();

  rc4_prga_decrypt #(.MSG_LEN(4), .MSG_AW(5), .MEM_RD_LAT(1)) dutA (
    .clk(clk), .reset(rst_q[0]), .bus(ifA.slave));
  rc4_prga_decrypt #(.MSG_LEN(9), .MSG_AW(5), .MEM_RD_LAT(2)) dutB (
    .clk(clk), .reset(rst_q[1]), .bus(ifB.slave));

  assign ifA.start   = start_q[0];
  assign ifB.start   = start_q[1];
  assign ifA.s_rdata = rd1[0];
  assign ifA.m_rdata = mr1[0];
  assign ifB.s_rdata = rd2[1];
  assign ifB.m_rdata = mr2[1];

  // S RAM and message ROM for engine A (latency 1).
  always @(posedge clk) begin
    if (ld[0]) for (int x = 0; x < 256; x++) mem[0][x] <= init_s[0][x];
    else if (ifA.s_we) mem[0][ifA.s_addr] <= ifA.s_wdata;
    rd1[0] <= mem[0][ifA.s_addr];
    rd2[0] <= rd1[0];
    mr1[0] <= msg[0][ifA.m_addr];
    mr2[0] <= mr1[0];
  end

  // S RAM and message ROM for engine B (latency 2).
  always @(posedge clk) begin
    if (ld[1]) for (int x = 0; x < 256; x++) mem[1][x] <= init_s[1][x];
    else if (ifB.s_we) mem[1][ifB.s_addr] <= ifB.s_wdata;
    rd1[1] <= mem[1][ifB.s_addr];
    rd2[1] <= rd1[1];
    mr1[1] <= msg[1][ifB.m_addr];
    mr2[1] <= mr1[1];
  end

  function automatic snap_t snap(input int u);
    snap_t s;
    if (u == 0) s = '{ifA.busy, ifA.done, ifA.fail, ifA.s_we, ifA.d_we,
                      ifA.s_addr, ifA.s_wdata, ifA.m_addr, ifA.d_addr, ifA.d_wdata};
    else        s = '{ifB.busy, ifB.done, ifB.fail, ifB.s_we, ifB.d_we,
                      ifB.s_addr, ifB.s_wdata, ifB.m_addr, ifB.d_addr, ifB.d_wdata};
    return s;
  endfunction

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_text(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
  endfunction

  // Plain RC4 PRGA over the model state; kf = index of first rejected byte or -1.
  task automatic model_run(input int u, input int len, output int kf);
    int i, j, si, sj;
    logic [7:0] o;
    kf = -1; i = mi[u]; j = mj[u];
    for (int k = 0; k < len; k++) begin
      i  = (i + 1) % 256;
      si = int'(mS[u][i]);
      j  = (j + si) % 256;
      sj = int'(mS[u][j]);
      mS[u][i] = 8'(sj);
      mS[u][j] = 8'(si);
      o = mS[u][(si + sj) % 256] ^ msg[u][k];
      if (CHK && !is_text(o)) begin
        kf = k;
        break;
      end
      expd[u][k] = o;
    end
    mi[u] = i; mj[u] = j;
  endtask

  task automatic load_s(input int u);
    for (int x = 0; x < 256; x++) mS[u][x] = init_s[u][x];
    @(negedge clk); ld[u] = 1'b1;
    @(negedge clk); ld[u] = 1'b0;
  endtask

  task automatic shuffle_s(input int u);
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) init_s[u][x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = init_s[u][x]; init_s[u][x] = init_s[u][r]; init_s[u][r] = t;
    end
  endtask

  task automatic ksa_key(input int u);
    logic [7:0] key [3];
    logic [7:0] t;
    int j;
    key[0] = "K"; key[1] = "e"; key[2] = "y";
    for (int x = 0; x < 256; x++) init_s[u][x] = 8'(x);
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + int'(init_s[u][x]) + int'(key[x % 3])) % 256;
      t = init_s[u][x]; init_s[u][x] = init_s[u][j]; init_s[u][j] = t;
    end
  endtask

  task automatic rand_msg(input int u);
    for (int k = 0; k < 32; k++) msg[u][k] = 8'($urandom);
  endtask

  // One full run on engine u, checked against the model.
  task automatic run(input int u, input int len, input int lat, input bit poke_busy);
    int kf, exp_done, c, done_cyc, ndone, nwr, busy_bad, ndiff;
    logic got_fail;
    snap_t s;
    model_run(u, len, kf);
    exp_done = (kf < 0) ? len * (6 + 3 * lat) + 1 : kf * (6 + 3 * lat) + 6 + 3 * lat;
    for (int k = 0; k < 32; k++) dgot[u][k] = 8'hEE;
    done_cyc = -1; ndone = 0; nwr = 0; busy_bad = 0; got_fail = 1'b0;
    @(negedge clk); start_q[u] = 1'b1;
    @(negedge clk); start_q[u] = 1'b0;
    c = 1;
    while (c <= exp_done + 40) begin
      s = snap(u);
      if (poke_busy && c == 5) start_q[u] = 1'b1;
      if (poke_busy && c == 6) start_q[u] = 1'b0;
      if (s.d_we) begin
        dgot[u][s.d_addr] = s.d_wdata;
        nwr++;
      end
      if (s.done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          got_fail = s.fail;
        end
      end
      if (c <= exp_done && s.busy !== (c < exp_done)) busy_bad++;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
      @(negedge clk);
      c++;
    end
    check_val($sformatf("done_cycle_u%0d", u), done_cyc, exp_done);
    check_val($sformatf("done_count_u%0d", u), ndone, 1);
    check_val($sformatf("fail_u%0d", u), got_fail, (kf >= 0));
    check_val($sformatf("busy_u%0d", u), busy_bad, 0);
    check_val($sformatf("d_writes_u%0d", u), nwr, (kf < 0) ? len : kf);
    for (int k = 0; k < ((kf < 0) ? len : kf); k++)
      check_val($sformatf("d%0d_u%0d", k, u), dgot[u][k], expd[u][k]);
    ndiff = 0;
    for (int x = 0; x < 256; x++) if (mem[u][x] !== mS[u][x]) ndiff++;
    check_val($sformatf("s_state_u%0d", u), ndiff, 0);
  endtask

  // Asynchronous reset in WR_SJ of byte 3 on engine A.
  task automatic reset_test();
    int c, nwr, nact, nbusy, ndone;
    snap_t s;
    shuffle_s(0); load_s(0); rand_msg(0);
    @(negedge clk); start_q[0] = 1'b1;
    @(negedge clk); start_q[0] = 1'b0;
    c = 1; nwr = 0;
    while (c < 33) begin
      s = snap(0);
      if (s.d_we) nwr++;
      @(negedge clk);
      c++;
    end
    s = snap(0);
    check_val("wr_sj_s_we", s.s_we, 1);
    check_val("pre_reset_d_writes", nwr, 3);
    #2 rst_q[0] = 1'b1;
    #1 s = snap(0);
    check_val("reset_async_outputs", s, 0);
    nact = 0; nbusy = 0; ndone = 0;
    repeat (3) begin
      @(negedge clk); s = snap(0);
      if (s.s_we || s.d_we) nact++;
    end
    rst_q[0] = 1'b0;
    repeat (30) begin
      @(negedge clk); s = snap(0);
      if (s.s_we || s.d_we) nact++;
      if (s.busy) nbusy++;
      if (s.done) ndone++;
    end
    check_val("post_reset_writes", nact, 0);
    check_val("post_reset_busy", nbusy, 0);
    check_val("post_reset_done", ndone, 0);
    mi[0] = 0; mj[0] = 0;
  endtask

  initial begin
    string pt;
    pt = "Plaintext";
    for (int u = 0; u < 2; u++) begin
      rst_q[u] = 1'b1; start_q[u] = 1'b0; ld[u] = 1'b0; mi[u] = 0; mj[u] = 0;
      for (int k = 0; k < 32; k++) msg[u][k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs_A", snap(0), 0);
    check_val("reset_outputs_B", snap(1), 0);
    @(negedge clk); rst_q[0] = 1'b0; rst_q[1] = 1'b0;

    // Identity S, zero message.
    for (int x = 0; x < 256; x++) init_s[0][x] = 8'(x);
    load_s(0);
    run(0, 4, 1, 1'b0);
`ifndef RC4_ASCII_CHECK_EN
    check_val("ident_d0", dgot[0][0], 8'h02);
    check_val("ident_d1", dgot[0][1], 8'h05);
`endif

    // Known vector: key "Key" -> "Plaintext", latency 2.
    ksa_key(1);
    load_s(1);
    msg[1][0] = 8'hBB; msg[1][1] = 8'hF3; msg[1][2] = 8'h16;
    msg[1][3] = 8'hE8; msg[1][4] = 8'hD9; msg[1][5] = 8'h40;
    msg[1][6] = 8'hAF; msg[1][7] = 8'h0A; msg[1][8] = 8'hD3;
    run(1, 9, 2, 1'b0);
`ifndef RC4_ASCII_CHECK_EN
    for (int k = 0; k < 9; k++)
      check_val($sformatf("plaintext_%0d", k), dgot[1][k], pt[k]);
`endif

    // start pulsed while busy; continues from current i, j, S.
    shuffle_s(0); load_s(0); rand_msg(0);
    run(0, 4, 1, 1'b1);

    // Back-to-back randomized runs keeping state between runs.
    shuffle_s(1); load_s(1);
    for (int r = 0; r < 4; r++) begin
      rand_msg(0); run(0, 4, 1, 1'b0);
      rand_msg(1); run(1, 9, 2, 1'b0);
    end

    reset_test();
    shuffle_s(0); load_s(0); rand_msg(0);
    run(0, 4, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
